// File: rtl/clz_pkg.sv
// Shared types and constants for the CLZ denormaliser pipeline.
// The payload carries the word together with its count and underflow flag.
package clz_pkg;

    localparam int WORD_W     = 64;
    localparam int CNT_W      = 8;
    localparam int NUM_STAGES = 6;

    // Stage k shifts by 32 >> k, the mirror of the CLZ normaliser order.
    localparam int SHIFT_TBL [NUM_STAGES] = '{32, 16, 8, 4, 2, 1};

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [CNT_W-1:0]  cnt;
        logic              uflow;
    } payload_t;

endpackage

// File: rtl/denorm_stage.sv
// One conditional logical right shift, optionally followed by an elastic
// valid/ready slot. Count and underflow flag ride along unchanged.
module denorm_stage
    import clz_pkg::*;
#(
    parameter int SHIFT      = 32,
    parameter int CNT_BIT    = 5,
    parameter bit REGISTERED = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     up_valid,
    output logic     up_ready,
    input  payload_t up_data,
    output logic     dn_valid,
    input  logic     dn_ready,
    output payload_t dn_data
);

    payload_t shifted;

    always_comb begin
        shifted = up_data;
        if (up_data.cnt[CNT_BIT]) begin
            shifted.word = up_data.word >> SHIFT;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic     valid_q;
            logic     valid_d;
            payload_t data_q;
            payload_t data_d;

            // The slot can take a new item when empty or when its item leaves now.
            assign up_ready = ~valid_q | dn_ready;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (up_ready) begin
                    valid_d = up_valid;
                    if (up_valid) begin
                        data_d = shifted;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign dn_valid = valid_q;
            assign dn_data  = data_q;
        end else begin : g_comb
            assign up_ready = dn_ready;
            assign dn_valid = up_valid;
            assign dn_data  = shifted;
        end
    endgenerate

endmodule

// File: rtl/clz_denorm_pipe.sv
// Reconstructs a word from its normalised form and leading-zero count by a
// logical right shift, built as six elastic conditional-shift stages.
module clz_denorm_pipe
    import clz_pkg::*;
#(
    parameter logic [NUM_STAGES-1:0] REG_MASK = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_VALID,
    output logic              o_READY,
    input  logic [WORD_W-1:0] i_WORD,
    input  logic [CNT_W-1:0]  i_RESULT,
    input  logic              i_ZERO,
    output logic              o_VALID,
    input  logic              i_READY,
    output logic [WORD_W-1:0] o_WORD,
    output logic              o_UFLOW
);

    logic     uflow;
    payload_t entry;

    logic     chain_valid [0:NUM_STAGES];
    logic     chain_ready [0:NUM_STAGES];
    payload_t chain_data  [0:NUM_STAGES];

    // Counts of 64 or more shift everything out; a zero source wins over underflow.
    always_comb begin
        uflow       = |i_RESULT[7:6];
        entry.word  = (i_ZERO | uflow) ? '0 : i_WORD;
        entry.cnt   = i_RESULT;
        entry.uflow = uflow & ~i_ZERO;
    end

    assign chain_valid[0]          = i_VALID;
    assign chain_data[0]           = entry;
    assign o_READY                 = chain_ready[0];
    assign chain_ready[NUM_STAGES] = i_READY;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            denorm_stage #(
                .SHIFT      (SHIFT_TBL[gi]),
                .CNT_BIT    (NUM_STAGES - 1 - gi),
                .REGISTERED (REG_MASK[gi])
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .up_valid (chain_valid[gi]),
                .up_ready (chain_ready[gi]),
                .up_data  (chain_data[gi]),
                .dn_valid (chain_valid[gi+1]),
                .dn_ready (chain_ready[gi+1]),
                .dn_data  (chain_data[gi+1])
            );
        end
    endgenerate

    assign o_VALID = chain_valid[NUM_STAGES];
    assign o_WORD  = chain_data[NUM_STAGES].word;
    assign o_UFLOW = chain_data[NUM_STAGES].uflow;

endmodule

// File: tb/tb_clz_denorm_pipe.sv
// Self-checking bench: directed cases plus random traffic against a queue model.
module tb_clz_denorm_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_VALID;
    logic        o_READY;
    logic [63:0] i_WORD;
    logic [7:0]  i_RESULT;
    logic        i_ZERO;
    logic        o_VALID;
    logic        i_READY;
    logic [63:0] o_WORD;
    logic        o_UFLOW;

    clz_denorm_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .i_VALID  (i_VALID),
        .o_READY  (o_READY),
        .i_WORD   (i_WORD),
        .i_RESULT (i_RESULT),
        .i_ZERO   (i_ZERO),
        .o_VALID  (o_VALID),
        .i_READY  (i_READY),
        .o_WORD   (o_WORD),
        .o_UFLOW  (o_UFLOW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic        uflow;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          emits = 0;
    int          accepts = 0;
    int          first_emit = -1;
    int          last_emit = -1;
    bit          chk_lat = 1'b0;
    bit          hold_prev = 1'b0;
    logic [63:0] hold_word;
    logic        hold_uflow;
    logic [63:0] last_word;
    logic        last_uflow;

    function automatic logic [63:0] ref_word(logic [63:0] w, int cnt, bit zero);
        if (zero || cnt >= 64) return 64'd0;
        return w >> cnt;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", 64'(o_VALID), 64'd1);
            chk("hold_word", o_WORD, hold_word);
            chk("hold_uflow", 64'(o_UFLOW), 64'(hold_uflow));
        end
        if (o_VALID && i_READY) begin
            if (sb.size() == 0) begin
                chk("spurious_emit", 64'(o_VALID), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_word", o_WORD, e.word);
                chk("out_uflow", 64'(o_UFLOW), 64'(e.uflow));
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd6);
                $display("cyc=%0d emit word=%h uflow=%0b", cyc, o_WORD, o_UFLOW);
            end
            emits++;
            last_word  = o_WORD;
            last_uflow = o_UFLOW;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
        end
        if (i_VALID && o_READY) begin
            e.word  = ref_word(i_WORD, int'(i_RESULT), i_ZERO);
            e.uflow = !i_ZERO && (i_RESULT >= 8'd64);
            e.cyc   = cyc;
            sb.push_back(e);
            accepts++;
            $display("cyc=%0d accept word=%h cnt=%0d zero=%0b", cyc, i_WORD, i_RESULT, i_ZERO);
        end
        hold_prev  = o_VALID && !i_READY;
        hold_word  = o_WORD;
        hold_uflow = o_UFLOW;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic send_one(logic [63:0] w, logic [7:0] cnt, logic zero);
        int a0 = accepts;
        int e0 = emits;
        int n  = 0;
        i_VALID = 1'b1; i_WORD = w; i_RESULT = cnt; i_ZERO = zero;
        while (accepts == a0 && n < 50) begin
            step();
            n++;
        end
        i_VALID = 1'b0;
        n = 0;
        while (emits == e0 && n < 30) begin
            step();
            n++;
        end
        chk("single_emitted", 64'(emits - e0), 64'd1);
    endtask

    task automatic reset_pulse(int n);
        reset   = 1'b1;
        i_VALID = 1'b0;
        i_READY = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        int          a0;
        int          e0;
        i_WORD = '0; i_RESULT = '0; i_ZERO = 1'b0; i_VALID = 1'b0; i_READY = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        reset_pulse(2);

        chk("reset_valid", 64'(o_VALID), 64'd0);
        chk("reset_word", o_WORD, 64'd0);
        chk("reset_uflow", 64'(o_UFLOW), 64'd0);
        chk("reset_ready", 64'(o_READY), 64'd1);

        i_READY = 1'b1;
        chk_lat = 1'b1;
        send_one(64'h8000_0000_0000_0000, 8'd0, 1'b0);
        chk("cnt0_word", last_word, 64'h8000_0000_0000_0000);
        chk("cnt0_uflow", 64'(last_uflow), 64'd0);
        send_one(64'h8000_0000_0000_0000, 8'd63, 1'b0);
        chk("cnt63_word", last_word, 64'h0000_0000_0000_0001);
        send_one(64'hC000_0000_0000_0001, 8'd33, 1'b0);
        chk("cnt33_word", last_word, 64'h0000_0000_6000_0000);
        send_one(64'hFFFF_FFFF_FFFF_FFFF, 8'd64, 1'b0);
        chk("cnt64_word", last_word, 64'd0);
        chk("cnt64_uflow", 64'(last_uflow), 64'd1);
        send_one(64'hFFFF_0000_FFFF_0000, 8'd200, 1'b1);
        chk("zero_word", last_word, 64'd0);
        chk("zero_uflow", 64'(last_uflow), 64'd0);

        // Back-to-back stream of 20 with counts 0..19.
        e0 = emits;
        first_emit = -1;
        for (int i = 0; i < 20; i++) begin
            i_VALID = 1'b1; i_WORD = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            i_RESULT = 8'(i); i_ZERO = 1'b0;
            step();
        end
        i_VALID = 1'b0;
        drain(40);
        chk("stream_count", 64'(emits - e0), 64'd20);
        chk("stream_contig", 64'(last_emit - first_emit), 64'd19);

        // Backpressure: six slots fill, then release with a 1-0-1 ready pulse.
        chk_lat = 1'b0;
        i_READY = 1'b0;
        a0 = accepts;
        e0 = emits;
        for (int i = 0; i < 10; i++) begin
            i_VALID = 1'b1; i_WORD = {$urandom, $urandom};
            i_RESULT = 8'($urandom_range(0, 70)); i_ZERO = 1'b0;
            step();
        end
        i_VALID = 1'b0;
        chk("bp_accepts", 64'(accepts - a0), 64'd6);
        chk("bp_ready_low", 64'(o_READY), 64'd0);
        i_READY = 1'b1; step();
        i_READY = 1'b0; step();
        i_READY = 1'b1;
        drain(30);
        chk("bp_emits", 64'(emits - e0), 64'd6);

        // Reset with four items in flight.
        chk_lat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_VALID = 1'b1; i_WORD = {$urandom, $urandom};
            i_RESULT = 8'(i + 1); i_ZERO = 1'b0;
            step();
        end
        reset_pulse(1);
        chk("midrst_valid", 64'(o_VALID), 64'd0);
        chk("midrst_word", o_WORD, 64'd0);
        chk("midrst_ready", 64'(o_READY), 64'd1);
        i_READY = 1'b1;
        e0 = emits;
        w = 64'hDEAD_BEEF_0123_4567;
        send_one(w, 8'd5, 1'b0);
        chk("post_rst_word", last_word, w >> 5);
        repeat (10) step();
        chk("post_rst_emits", 64'(emits - e0), 64'd1);

        // Random traffic with random backpressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            i_VALID = ($urandom_range(0, 3) != 0);
            i_READY = ($urandom_range(0, 3) != 0);
            i_WORD  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0, 1:    i_RESULT = 8'($urandom_range(0, 63));
                2:       i_RESULT = 8'($urandom_range(64, 255));
                default: i_RESULT = 8'($urandom_range(0, 255));
            endcase
            i_ZERO = ($urandom_range(0, 7) == 0);
            step();
        end
        i_VALID = 1'b0;
        i_READY = 1'b1;
        drain(40);
        chk("final_accepts_eq_emits", 64'(emits), 64'(accepts - 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clz_denorm_pipe.md
Name: clz_denorm_pipe

Overview:
- Inverse of the log2 CLZ normaliser chain: takes a normalised 64-bit word and its leading-zero count (uint8) and reconstructs the original word by a logical right shift of count bits.
- Built as six conditional-shift stages (32, 16, 8, 4, 2, 1), the mirror image of the CLZ stage chain. Each stage has an elastic pipeline slot with valid/ready flow control.
- Sits on the exp2/antilog return path, downstream of the fractional-power unit.

Parameters:
- WORD_W, 64, data word width. Fixed at 64; other values unsupported.
- CNT_W, 8, count width (uint8, matches the CLZ result).
- REG_MASK, 6'b111111, bit k=1 puts a register slot after shift stage k (k=0 is the 32-bit stage). A 0 bit makes that stage combinational pass-through. Latency = popcount(REG_MASK).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_VALID  in  1  input word/count valid
- o_READY  out  1  block can accept input this cycle
- i_WORD  in  64  normalised word (ufix64, MSB normally set)
- i_RESULT  in  8  leading-zero count (uint8)
- i_ZERO  in  1  original word was zero; output is forced to 0
- o_VALID  out  1  output valid
- i_READY  in  1  downstream accepts output
- o_WORD  out  64  denormalised word (ufix64)
- o_UFLOW  out  1  count ≥ 64 was presented; o_WORD = 0

Behaviour:
- Reset (clk edge with reset=1): all slot valids, data and flags cleared. o_VALID=0, o_WORD=0, o_UFLOW=0. o_READY=1 in the cycle after reset. Reset mid-operation discards all in-flight items silently.
- Stage k (shift S = 32>>k):
  - Data: word_out = count[5-k] ? (word_in >> S) : word_in. Logical shift, zero fill, low bits truncated, no rounding.
  - Count and flags pass through unchanged.
- Entry pre-processing, combinational before stage 0:
  - uflow = |i_RESULT[7:6].
  - If i_ZERO or uflow, the word entering stage 0 is 0.
  - o_UFLOW = uflow & ~i_ZERO (i_ZERO takes priority).
- Handshake, per registered slot:
  - ready_k = ~valid_k | ready_{k+1}; ready after the last slot = i_READY.
  - o_READY = ready of the first registered slot (i_READY if REG_MASK=0).
  - Transfer in occurs when i_VALID & o_READY. A slot loads when its upstream is valid and ready_k=1.
  - A slot's valid clears when it empties without refill.
- Throughput: one item per cycle with i_READY held high. Accept and emit in the same cycle is allowed and keeps occupancy constant.
- Backpressure: while o_VALID & ~i_READY, o_WORD and o_UFLOW stay stable. No item is dropped or duplicated. Up to popcount(REG_MASK) items are buffered; o_READY falls only when every slot is full.
- i_WORD/i_RESULT are ignored when i_VALID=0. Slot data is not cleared on emit; only valid matters.
- Ordering is strictly FIFO.
- Count boundaries:
  - count 0 → word unchanged.
  - count 63 → only the original MSB survives, at bit 0.
  - count 64..255 → 0 with UFLOW.
- Latency: default 6 cycles from accepted input to o_VALID, with no backpressure.

Decomposition:
- Package clz_pkg holds:
  - WORD_W = 64, CNT_W = 8
  - stage shift constants SHIFT_TBL = {32, 16, 8, 4, 2, 1}
  - payload struct {word[63:0], cnt[7:0], uflow}
- Sub-module denorm_stage (parameters SHIFT, CNT_BIT, REGISTERED): one conditional shift plus an optional elastic slot. Instantiated six times by the top, which also owns the entry pre-processing.

Test Plan:
- i_WORD=0x8000_0000_0000_0000, i_RESULT=0, i_READY=1 → after 6 cycles o_VALID=1, o_WORD=0x8000_0000_0000_0000, o_UFLOW=0. Same word with i_RESULT=63 → o_WORD=0x0000_0000_0000_0001.
- i_WORD=0xC000_0000_0000_0001, i_RESULT=33 → o_WORD=0x0000_0000_6000_0000 (LSB truncated).
- i_RESULT=64 → o_WORD=0, o_UFLOW=1. i_RESULT=200 with i_ZERO=1 → o_WORD=0, o_UFLOW=0.
- Stream 20 back-to-back items with counts 0..19, i_READY=1 → 20 consecutive o_VALID cycles, in order, each matching a reference model (i_WORD >> count).
- Hold i_READY=0 while streaming → o_READY falls after 6 accepts and o_WORD stays stable. Then pulse i_READY 1-0-1 → the exact 6 items emit in order with no loss or duplication.
- Assert reset for 1 cycle with 4 items in flight → o_VALID=0 and o_WORD=0 next cycle, o_READY=1. A new item issued afterwards emits correctly after 6 cycles, and none of the stale items appear.
